// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the HI/LO unit: issues MULTU to an external iterative
// shift-add multiplier, captures the 64-bit product into HI/LO, and serves MFHI/MFLO.
module mult_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        stall,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_load,
    output logic        mul_step,
    input  logic [63:0] mul_product,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        busy
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned LAST_STEP = 31;

    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MFHI  = 2'b10;
    localparam logic [1:0] OP_MFLO  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        RUN   = 2'b10,
        WRITE = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   mul_a_q, mul_a_d;
    logic [DATA_W-1:0]   mul_b_q, mul_b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                op_ready_q;
    logic                busy_q;
    logic                mul_load_q;
    logic                mul_step_q;
    logic                accept;

    // op_ready_q mirrors "state is IDLE", so it doubles as the acceptance qualifier
    assign accept = op_valid & op_ready_q;

    // Next-state and datapath
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_MULTU: begin
                            mul_a_d = op_a;
                            mul_b_d = op_b;
                            state_d = LOAD;
                        end
                        OP_MFHI: begin
                            result_d       = hi_q;
                            result_valid_d = 1'b1;
                        end
                        OP_MFLO: begin
                            result_d       = lo_q;
                            result_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LAST_STEP)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                hi_d    = mul_product[2*DATA_W-1:DATA_W];
                lo_d    = mul_product[DATA_W-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; strobes are decoded from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            op_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
            mul_load_q     <= 1'b0;
            mul_step_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            op_ready_q     <= (state_d == IDLE);
            busy_q         <= (state_d != IDLE);
            mul_load_q     <= (state_d == LOAD);
            mul_step_q     <= (state_d == RUN);
        end
    end

    assign op_ready     = op_ready_q;
    assign stall        = op_valid & ~op_ready_q;
    assign busy         = busy_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_load     = mul_load_q;
    assign mul_step     = mul_step_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 The block SHALL take reset as a synchronous, active-high reset and clk as its clock; all state SHALL update on the rising edge of clk only.
REQ-002 Port clk  input  1  system clock.
REQ-003 Port reset  input  1  synchronous active-high reset.
REQ-004 Port op_valid  input  1  the decode stage presents an HI/LO-unit operation.
REQ-005 Port op_code  input  2  operation code: 00 NOP, 01 MULTU, 10 MFHI, 11 MFLO.
REQ-006 Port op_a  input  32  MULTU multiplicand (rs value).
REQ-007 Port op_b  input  32  MULTU multiplier (rt value).
REQ-008 Port op_ready  output  1  the controller accepts an operation this cycle.
REQ-009 Port stall  output  1  the pipeline must hold decode this cycle.
REQ-010 Port mul_a  output  32  operand A, registered, to the iterative shift-add multiplier.
REQ-011 Port mul_b  output  32  operand B, registered, to the multiplier.
REQ-012 Port mul_load  output  1  one-cycle pulse; the multiplier loads mul_a/mul_b and clears its product.
REQ-013 Port mul_step  output  1  the multiplier performs one shift-add iteration.
REQ-014 Port mul_product  input  64  the multiplier's 64-bit product.
REQ-015 Port result_valid  output  1  one-cycle pulse; result holds MFHI/MFLO data.
REQ-016 Port result  output  32  registered move-from data.
REQ-017 Port busy  output  1  a multiply is in progress.

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD, RUN, WRITE.
REQ-019 op_ready SHALL be 1 exactly when the state is IDLE; an operation is accepted when op_valid and op_ready are both 1.
REQ-020 stall SHALL equal op_valid AND NOT op_ready, combinationally.
REQ-021 busy SHALL be 1 in LOAD, RUN and WRITE, and 0 in IDLE.
REQ-022 An accepted MULTU in cycle T SHALL latch op_a into mul_a and op_b into mul_b, and move the FSM to LOAD.
REQ-023 In LOAD (cycle T+1), mul_load SHALL be 1 for exactly one cycle, the 6-bit iteration counter SHALL clear to 0, and the FSM SHALL move to RUN.
REQ-024 In RUN, mul_step SHALL be 1 every cycle and the counter SHALL increment by 1 per cycle.
REQ-025 The FSM SHALL leave RUN for WRITE after the cycle in which the counter equals 31, giving exactly 32 mul_step cycles (T+2..T+33).
REQ-026 In WRITE (T+34), HI SHALL capture mul_product[63:32] and LO SHALL capture mul_product[31:0], and the FSM SHALL return to IDLE; the new HI/LO values SHALL be visible from T+35.
REQ-027 mul_load and mul_step SHALL never be 1 in the same cycle, and SHALL both be 0 in IDLE and WRITE.
REQ-028 An accepted MFHI in cycle T SHALL drive result = HI and result_valid = 1 in cycle T+1 only; MFLO SHALL do the same with LO.
REQ-029 An accepted NOP SHALL have no effect.
REQ-030 Any operation presented while busy SHALL NOT be accepted; it SHALL be held by stall until the first IDLE cycle and then be accepted.
REQ-031 MFHI/MFLO issued after a MULTU SHALL return the new product: it is accepted no earlier than T+35, and result is valid at T+36.
REQ-032 result SHALL hold its last value when result_valid is 0; the FSM SHALL ignore op_a and op_b in every state except on MULTU acceptance.
REQ-033 The multiplication SHALL be unsigned; the full 64-bit product SHALL be captured with no truncation or overflow flag.

Reset
REQ-034 When reset is 1 at a clock edge, the FSM SHALL go to IDLE, and the counter, HI, LO, mul_a, mul_b and result SHALL all clear to 0.
REQ-035 After that reset edge, mul_load, mul_step and result_valid SHALL be 0, busy SHALL be 0, and op_ready SHALL be 1.
REQ-036 reset SHALL take priority over every operation; a reset during LOAD, RUN or WRITE SHALL abort the multiply with HI/LO = 0 and no partial result captured.

Verification
REQ-037 Using the team's iterative multiplier model: MULTU 3 x 5, then MFLO -> mul_load at T+1, 32 mul_step pulses, then MFLO result 0x0000000F and MFHI result 0x00000000.
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-039 MFHI presented at T+1 after a MULTU accepted at T -> stall = 1 during T+1..T+34, accepted at T+35, result_valid at T+36 with the new HI.
REQ-040 Reset asserted on the 10th mul_step cycle -> next cycle IDLE, busy = 0, mul_step = 0; a following MFLO returns 0x00000000.
REQ-041 Back-to-back MULTU 7 x 6 then MULTU 0x10000 x 0x10000 with no idle gap -> second accepted at T+35; final HI = 0x00000001, LO = 0x00000000.
REQ-042 NOP and MFLO issued in IDLE with op_valid pulsed each cycle -> never stalled, one result_valid per MFLO, HI/LO unchanged.
